// File: rtl/car_pkg.sv
// Shared car-body definitions: turn-indicator state encoding and the car mode constant.
// Used by both the turn-switch conditioner and the lamp driver.
package car_pkg;

    typedef enum logic [1:0] {
        TS_IDLE   = 2'd0,
        TS_LEFT   = 2'd1,
        TS_RIGHT  = 2'd2,
        TS_HAZARD = 2'd3
    } ts_state_e;

    localparam logic [1:0] MODE_OFF = 2'b00;

    function automatic logic is_powered(input logic [1:0] mode);
        return mode != MODE_OFF;
    endfunction

endpackage

// File: rtl/turn_signal_ctrl_if.sv
// Switch/mode inputs and level requests between the turn-switch conditioner and its neighbours.
// master drives switches and mode; slave (the conditioner) drives the requests and debug state.
interface turn_signal_ctrl_if;
    import car_pkg::*;

    logic [1:0] mode;
    logic       left_btn;
    logic       right_btn;
    logic       turn_left;
    logic       turn_right;
    ts_state_e  state;

    modport master (
        output mode, left_btn, right_btn,
        input  turn_left, turn_right, state
    );

    modport slave (
        input  mode, left_btn, right_btn,
        output turn_left, turn_right, state
    );

endinterface

// File: rtl/turn_debounce.sv
// 2-flop synchroniser plus counter debouncer for one raw switch.
// Latency 2 + DEBOUNCE_CYCLES cycles from raw edge to filtered change; no backpressure.
module turn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_filt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q,  filt_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] cnt_inc;

    // Any sample matching the filtered value restarts the stability count.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        cnt_inc = cnt_q + CW'(1);
        if (sync2_q != filt_q) begin
            if (cnt_inc == CNT_MAX) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_filt = filt_q;

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-switch conditioner: debounced switches drive a min-hold FSM; HAZARD exists only with TURN_HAZARD_EN.
// Latency 2 + DEBOUNCE_CYCLES + 1 cycles raw edge to request; no backpressure, level outputs.
module turn_signal_ctrl
    import car_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MIN_HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    turn_signal_ctrl_if.slave bus
);

    localparam int HW = $clog2(MIN_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD_CYCLES);

    logic fl, fr;

    turn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (bus.left_btn),
        .btn_filt (fl)
    );

    turn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (bus.right_btn),
        .btn_filt (fr)
    );

    ts_state_e     state_q, state_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic [HW-1:0] hold_dec;
    logic          hold_zero;
    logic          turn_left_q,  turn_left_d;
    logic          turn_right_q, turn_right_d;

    always_comb begin
        state_d   = state_q;
        hold_zero = (hold_q == '0);
        hold_dec  = hold_zero ? '0 : hold_q - HW'(1);

        case (state_q)
            TS_IDLE: begin
                if (fl && !fr)      state_d = TS_LEFT;
                else if (fr && !fl) state_d = TS_RIGHT;
`ifdef TURN_HAZARD_EN
                else if (fl && fr)  state_d = TS_HAZARD;
`endif
            end
            TS_LEFT: begin
                if (fr && !fl)                     state_d = TS_RIGHT;
`ifdef TURN_HAZARD_EN
                else if (fl && fr)                 state_d = TS_HAZARD;
`endif
                else if (!fl && !fr && hold_zero)  state_d = TS_IDLE;
            end
            TS_RIGHT: begin
                if (fl && !fr)                     state_d = TS_LEFT;
`ifdef TURN_HAZARD_EN
                else if (fl && fr)                 state_d = TS_HAZARD;
`endif
                else if (!fl && !fr && hold_zero)  state_d = TS_IDLE;
            end
            default: begin
                if (hold_zero) begin
                    if (!fl && !fr)     state_d = TS_IDLE;
                    else if (fl && !fr) state_d = TS_LEFT;
                    else if (fr && !fl) state_d = TS_RIGHT;
                end
            end
        endcase

        // A fresh non-IDLE entry restarts the minimum on-time.
        if (state_d == TS_IDLE)       hold_d = '0;
        else if (state_d != state_q)  hold_d = HOLD_LOAD;
        else                          hold_d = hold_dec;

        if (!is_powered(bus.mode)) begin
            state_d = TS_IDLE;
            hold_d  = '0;
        end

        turn_left_d  = (state_d == TS_LEFT)  || (state_d == TS_HAZARD);
        turn_right_d = (state_d == TS_RIGHT) || (state_d == TS_HAZARD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= TS_IDLE;
            hold_q       <= '0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            turn_left_q  <= turn_left_d;
            turn_right_q <= turn_right_d;
        end
    end

    assign bus.turn_left  = turn_left_q;
    assign bus.turn_right = turn_right_q;
    assign bus.state      = state_q;

endmodule

// File: doc/turn_signal_ctrl.md
# turn_signal_ctrl

Upstream stage of the car indicator lamp driver: conditions the raw left/right turn-switch inputs and produces the clean `turn_left` / `turn_right` level requests that the lamp driver blinks. Synchronises and debounces both switches, enforces a minimum indicator on-time so a short tap still gives a visible blink, and forces everything off while the car is powered down. Runs on the system clock alongside the lamp driver and shares its `mode` input.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples needed before a switch change is accepted (10 ms at 100 MHz).
- `MIN_HOLD_CYCLES`, default 50_000_000: minimum cycles a request stays asserted after entry (0.5 s at 100 MHz).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mode`  in  2  car mode; `2'b00` = power off, any other value = powered.
- `left_btn`  in  1  raw, asynchronous left turn switch, active-high.
- `right_btn`  in  1  raw, asynchronous right turn switch, active-high.
- `turn_left`  out  1  registered left request to the lamp driver.
- `turn_right`  out  1  registered right request to the lamp driver.
- `state`  out  2  current FSM state, for debug and LED display.

## Operation
- Each switch passes through a 2-flop synchroniser, then a debouncer. The debouncer has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`. It clears whenever the synchronised sample equals the filtered value. When the counter reaches `DEBOUNCE_CYCLES`, the filtered value takes the sample and the counter clears.
- FSM states: IDLE=0, LEFT=1, RIGHT=2, HAZARD=3. `fl`/`fr` are the filtered switch values.
- IDLE: `fl & ~fr` → LEFT; `fr & ~fl` → RIGHT; `fl & fr` → HAZARD (see Configuration).
- LEFT: `fr & ~fl` → RIGHT; `fl & fr` → HAZARD; `~fl` and hold counter = 0 → IDLE. RIGHT mirrors LEFT.
- HAZARD: both released and hold = 0 → IDLE; exactly one still pressed and hold = 0 → that direction.
- Hold counter has width `$clog2(MIN_HOLD_CYCLES+1)`. It loads `MIN_HOLD_CYCLES` on every state entry other than IDLE, decrements to 0 while in a non-IDLE state, and saturates at 0.
- Outputs are decoded from the registered state: LEFT → `turn_left`=1; RIGHT → `turn_right`=1; HAZARD → both 1; IDLE → both 0.
- `mode == 2'b00` overrides all transitions: the next state is IDLE and the hold counter clears. Debouncers keep running, so a switch held through power-up is honoured once powered.
- Reset clears synchronisers, debounce counters, filtered values (0), FSM (IDLE) and hold counter. All outputs reset to 0. Reset asserted mid-indication drops outputs on the next edge.

## Timing
- Raw edge to output change is 2 (sync) + `DEBOUNCE_CYCLES` + 1 (FSM) cycles, provided the hold counter is not blocking.
- Release of a switch does not deassert the output until the later of debounced release and hold expiry. The output falls on the edge after the hold counter reads 0 with the switch released.
- A direction change (LEFT↔RIGHT) takes effect immediately on the debounced press, with no gap cycle. Outputs are never both 1 except in HAZARD.
- The `mode` off → IDLE transition takes 1 cycle.

## Configuration
- `TURN_HAZARD_EN` defined: the HAZARD state exists as described.
- `TURN_HAZARD_EN` undefined: `fl & fr` is treated as "no new request". IDLE stays IDLE. LEFT/RIGHT stay put and keep counting down; they exit to IDLE only when both switches are released and hold = 0. The encoding 3 is never reached.

## Structure
- Shared package `car_pkg` holds the state enum (`TS_IDLE`, `TS_LEFT`, `TS_RIGHT`, `TS_HAZARD`) and the mode constant `MODE_OFF = 2'b00`. The lamp driver uses the same mode constant.
- One sub-module, `turn_debounce` (synchroniser + debouncer, parameterised by `DEBOUNCE_CYCLES`), is instantiated twice.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4, `MIN_HOLD_CYCLES`=10, `mode`=01 unless stated.
- Left held 20 cycles → `turn_left` rises exactly 7 cycles after the raw edge; `turn_right` stays 0; `state`=1.
- Left tapped for 5 cycles → `turn_left` high for 11 cycles (hold-limited), then 0 and `state`=0.
- Left glitch of 3 cycles, repeated with 1-cycle gaps → outputs never assert.
- In LEFT, press right (left released) → `turn_right` rises on the same edge `turn_left` falls, with no overlap.
- Both pressed together → with `TURN_HAZARD_EN` both outputs become 1 and `state`=3; without it both stay 0.
- In LEFT, set `mode`=00 → both outputs 0 on the next edge. Assert `rst` during RIGHT → outputs 0 and `state`=0 on the next edge.
